// File: rtl/writeback_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : writeback_unit_pkg
// Description : Shared core definitions for the writeback unit: register
//               index / data widths, register count and the ALU skid-buffer
//               state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package writeback_unit_pkg;

  localparam int REG_IDX_W = 5;
  localparam int DATA_W    = 32;
  localparam int NUM_REGS  = 32;

  // ALU skid buffer: EMPTY accepts a new ALU result, HELD owns one that is
  // waiting for a free write slot.
  typedef enum logic [0:0] {
    SKID_EMPTY = 1'b0,
    SKID_HELD  = 1'b1
  } skid_state_e;

endpackage : writeback_unit_pkg
`default_nettype wire

// File: rtl/writeback_unit_load_queue.sv
`default_nettype none
// ============================================================================
// Module      : wb_load_queue
// Description : In-order FIFO of outstanding load destination registers.
//               Wrap-around read/write pointers plus an occupancy count.
//               With WB_SCOREBOARD_EN defined, per-entry rd/valid outputs are
//               exported so the parent can build a busy-register mask.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_load_queue
  import writeback_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             push,
  input  logic [REG_IDX_W-1:0]             push_rd,
  input  logic                             pop,
  output logic [REG_IDX_W-1:0]             head_rd,
  output logic                             full,
`ifdef WB_SCOREBOARD_EN
  output logic [DEPTH-1:0][REG_IDX_W-1:0]  entry_rd,
  output logic [DEPTH-1:0]                 entry_valid,
`endif
  output logic                             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

  logic [DEPTH-1:0][REG_IDX_W-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]                wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]                rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]                count_q, count_d;
  logic                            push_ok;
  logic                            pop_ok;

  assign full    = (count_q == CNT_DEPTH);
  assign empty   = (count_q == '0);
  assign head_rd = mem_q[rd_ptr_q];

  // Guard against overflow/underflow even if the parent misbehaves.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_rd;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Queue state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

`ifdef WB_SCOREBOARD_EN
  // An entry is live when its distance from the read pointer (mod DEPTH)
  // is below the occupancy count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    localparam logic [PTR_W-1:0] IDX = PTR_W'(i);
    logic [PTR_W-1:0] offset;
    assign offset         = IDX - rd_ptr_q;
    assign entry_valid[i] = ({1'b0, offset} < count_q);
    assign entry_rd[i]    = mem_q[i];
  end
`endif

endmodule : wb_load_queue
`default_nettype wire

// File: rtl/writeback_unit.sv
`default_nettype none
// ============================================================================
// Module      : writeback_unit
// Description : Register-file writeback arbiter. Load returns (in issue
//               order, destinations tracked in wb_load_queue) take priority;
//               a colliding ALU result is parked in a one-entry skid buffer
//               and written on the next free slot. Writes to x0 are dropped.
//               Macro WB_SCOREBOARD_EN enables the busy_mask decode; without
//               it busy_mask is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_unit
  import writeback_unit_pkg::*;
#(
  parameter int LQ_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alu_valid,
  input  logic [4:0]           alu_rd,
  input  logic [31:0]          alu_data,
  output logic                 alu_ready,
  input  logic                 ld_issue,
  input  logic [4:0]           ld_rd,
  output logic                 ld_ready,
  input  logic                 mem_rvalid,
  input  logic [31:0]          mem_rdata,
  output logic                 regwrite,
  output logic [4:0]           rd,
  output logic [31:0]          rd_data,
  output logic [31:0]          busy_mask,
  output logic                 err_underflow
);

  skid_state_e          state_q, state_d;
  logic [REG_IDX_W-1:0] skid_rd_q, skid_rd_d;
  logic [DATA_W-1:0]    skid_data_q, skid_data_d;
  logic                 regwrite_q, regwrite_d;
  logic [REG_IDX_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0]    rd_data_q, rd_data_d;
  logic                 err_q, err_d;

  logic                 lq_full;
  logic                 lq_empty;
  logic [REG_IDX_W-1:0] lq_head_rd;
  logic                 lq_push;
  logic                 lq_pop;
  logic                 underflow;
  logic                 alu_accept;
  logic                 wr_en;
  logic [REG_IDX_W-1:0] wr_rd;
  logic [DATA_W-1:0]    wr_data;

`ifdef WB_SCOREBOARD_EN
  logic [LQ_DEPTH-1:0][REG_IDX_W-1:0] lq_entry_rd;
  logic [LQ_DEPTH-1:0]                lq_entry_valid;
`endif

  // ld_ready is purely !full: a same-cycle pop does not open a slot early.
  assign ld_ready   = !lq_full;
  assign lq_push    = ld_issue && !lq_full;
  assign lq_pop     = mem_rvalid && !lq_empty;
  assign underflow  = mem_rvalid && lq_empty;
  assign alu_ready  = (state_q == SKID_EMPTY);
  assign alu_accept = alu_valid && alu_ready;

  wb_load_queue #(
    .DEPTH       (LQ_DEPTH)
  ) u_load_queue (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (lq_push),
    .push_rd     (ld_rd),
    .pop         (lq_pop),
    .head_rd     (lq_head_rd),
    .full        (lq_full),
`ifdef WB_SCOREBOARD_EN
    .entry_rd    (lq_entry_rd),
    .entry_valid (lq_entry_valid),
`endif
    .empty       (lq_empty)
  );

  // Write-slot arbitration: load return first, then skid drain, then ALU.
  always_comb begin
    state_d     = state_q;
    skid_rd_d   = skid_rd_q;
    skid_data_d = skid_data_q;
    wr_en       = 1'b0;
    wr_rd       = '0;
    wr_data     = '0;
    if (lq_pop) begin
      wr_en   = 1'b1;
      wr_rd   = lq_head_rd;
      wr_data = mem_rdata;
      if (alu_accept) begin
        skid_rd_d   = alu_rd;
        skid_data_d = alu_data;
        state_d     = SKID_HELD;
      end
    end else if (state_q == SKID_HELD) begin
      wr_en   = 1'b1;
      wr_rd   = skid_rd_q;
      wr_data = skid_data_q;
      state_d = SKID_EMPTY;
    end else if (alu_accept) begin
      wr_en   = 1'b1;
      wr_rd   = alu_rd;
      wr_data = alu_data;
    end
  end

  // Register-port next values; x0 writes and idle cycles hold rd/rd_data.
  always_comb begin
    regwrite_d = wr_en && (wr_rd != '0);
    rd_d       = rd_q;
    rd_data_d  = rd_data_q;
    if (regwrite_d) begin
      rd_d      = wr_rd;
      rd_data_d = wr_data;
    end
    err_d = err_q || underflow;
  end

  // Skid buffer, write port and sticky error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SKID_EMPTY;
      skid_rd_q   <= '0;
      skid_data_q <= '0;
      regwrite_q  <= 1'b0;
      rd_q        <= '0;
      rd_data_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      skid_rd_q   <= skid_rd_d;
      skid_data_q <= skid_data_d;
      regwrite_q  <= regwrite_d;
      rd_q        <= rd_d;
      rd_data_q   <= rd_data_d;
      err_q       <= err_d;
    end
  end

  assign regwrite      = regwrite_q;
  assign rd            = rd_q;
  assign rd_data       = rd_data_q;
  assign err_underflow = err_q;

`ifdef WB_SCOREBOARD_EN
  // Busy decode from the registered queue entries; x0 is never busy.
  always_comb begin
    busy_mask = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      for (int e = 0; e < LQ_DEPTH; e++) begin
        if (lq_entry_valid[e] && (lq_entry_rd[e] == REG_IDX_W'(r))) begin
          busy_mask[r] = 1'b1;
        end
      end
    end
  end
`else
  assign busy_mask = 32'd0;
`endif

endmodule : writeback_unit
`default_nettype wire

// File: tb/tb_writeback_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_unit
// Description : Self-checking bench for writeback_unit. Directed stimulus
//               pushes expected register writes into a queue; a monitor
//               pops and compares on every regwrite. Busy-mask expectations
//               follow WB_SCOREBOARD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_unit;

  logic        clk;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        ld_issue;
  logic [4:0]  ld_rd;
  logic        ld_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        regwrite;
  logic [4:0]  rd;
  logic [31:0] rd_data;
  logic [31:0] busy_mask;
  logic        err_underflow;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  writeback_unit #(
    .LQ_DEPTH      (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .alu_valid     (alu_valid),
    .alu_rd        (alu_rd),
    .alu_data      (alu_data),
    .alu_ready     (alu_ready),
    .ld_issue      (ld_issue),
    .ld_rd         (ld_rd),
    .ld_ready      (ld_ready),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .regwrite      (regwrite),
    .rd            (rd),
    .rd_data       (rd_data),
    .busy_mask     (busy_mask),
    .err_underflow (err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_busy(input logic [31:0] m);
`ifdef WB_SCOREBOARD_EN
    return m;
`else
    return 32'd0;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [4:0] r, input logic [31:0] d);
    exp_t e;
    e.rd   = r;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Monitor: every register write must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && regwrite) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got rd=%0d data=0x%0h expected no write", rd, rd_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (rd !== e.rd || rd_data !== e.data) begin
          n_fail++;
          $display("FAIL write: got rd=%0d data=0x%0h expected rd=%0d data=0x%0h",
                   rd, rd_data, e.rd, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_regwrite"}, {31'd0, regwrite}, 32'd0);
    chk({tag, "_rd"}, {27'd0, rd}, 32'd0);
    chk({tag, "_rd_data"}, rd_data, 32'd0);
    chk({tag, "_busy"}, busy_mask, 32'd0);
    chk({tag, "_err"}, {31'd0, err_underflow}, 32'd0);
    chk({tag, "_ld_ready"}, {31'd0, ld_ready}, 32'd1);
    chk({tag, "_alu_ready"}, {31'd0, alu_ready}, 32'd1);
  endtask

  initial begin
    rst_n      = 1'b0;
    alu_valid  = 1'b0;
    alu_rd     = 5'd0;
    alu_data   = 32'd0;
    ld_issue   = 1'b0;
    ld_rd      = 5'd0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    step();

    // Plain ALU write.
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
    expect_wr(5'd5, 32'h1234);
    step();
    alu_valid = 1'b0;
    chk("alu_regwrite", {31'd0, regwrite}, 32'd1);
    step();

    // Two loads, in-order returns, busy mask shrinking.
    ld_issue = 1'b1; ld_rd = 5'd3;
    step();
    ld_rd = 5'd7;
    step();
    ld_issue = 1'b0;
    chk("busy_two_loads", busy_mask, exp_busy(32'h88));
    mem_rvalid = 1'b1; mem_rdata = 32'hAA;
    expect_wr(5'd3, 32'hAA);
    step();
    chk("busy_one_load", busy_mask, exp_busy(32'h80));
    mem_rdata = 32'hBB;
    expect_wr(5'd7, 32'hBB);
    step();
    mem_rvalid = 1'b0;
    chk("busy_no_load", busy_mask, exp_busy(32'h0));
    step();

    // ALU collides with a load return: load first, ALU from the skid.
    ld_issue = 1'b1; ld_rd = 5'd4;
    step();
    ld_issue = 1'b0;
    chk("alu_ready_before_collide", {31'd0, alu_ready}, 32'd1);
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h55;
    mem_rvalid = 1'b1; mem_rdata = 32'h66;
    expect_wr(5'd4, 32'h66);
    expect_wr(5'd9, 32'h55);
    step();
    alu_valid = 1'b0; mem_rvalid = 1'b0;
    chk("alu_ready_held", {31'd0, alu_ready}, 32'd0);
    step();
    chk("alu_ready_drained", {31'd0, alu_ready}, 32'd1);
    step();

    // Fill the queue, try a fifth issue, then drain.
    ld_issue = 1'b1;
    ld_rd = 5'd1;  step();
    ld_rd = 5'd2;  step();
    ld_rd = 5'd10; step();
    ld_rd = 5'd11; step();
    ld_issue = 1'b0;
    chk("ld_ready_full", {31'd0, ld_ready}, 32'd0);
    chk("busy_full", busy_mask, exp_busy(32'h0000_0C06));
    ld_issue = 1'b1; ld_rd = 5'd20;
    step();
    ld_issue = 1'b0;
    chk("ld_ready_after_ignored", {31'd0, ld_ready}, 32'd0);
    chk("busy_after_ignored", busy_mask, exp_busy(32'h0000_0C06));
    mem_rvalid = 1'b1; mem_rdata = 32'h11;
    expect_wr(5'd1, 32'h11);
    step();
    mem_rvalid = 1'b0;
    chk("ld_ready_after_pop", {31'd0, ld_ready}, 32'd1);
    mem_rvalid = 1'b1;
    mem_rdata = 32'h22; expect_wr(5'd2, 32'h22);  step();
    mem_rdata = 32'h33; expect_wr(5'd10, 32'h33); step();
    mem_rdata = 32'h44; expect_wr(5'd11, 32'h44); step();
    mem_rvalid = 1'b0;
    chk("busy_drained", busy_mask, exp_busy(32'h0));
    step();

    // Underflow and x0 write.
    chk("err_clear_before", {31'd0, err_underflow}, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD;
    step();
    mem_rvalid = 1'b0;
    chk("err_underflow_set", {31'd0, err_underflow}, 32'd1);
    chk("underflow_no_write", {31'd0, regwrite}, 32'd0);
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h99;
    step();
    alu_valid = 1'b0;
    chk("x0_no_write", {31'd0, regwrite}, 32'd0);
    chk("x0_rd_held", {27'd0, rd}, 32'd11);
    chk("x0_data_held", rd_data, 32'h44);
    chk("err_sticky", {31'd0, err_underflow}, 32'd1);
    step();

    // Reset with two loads pending and the skid HELD.
    ld_issue = 1'b1;
    ld_rd = 5'd6;  step();
    ld_rd = 5'd8;  step();
    ld_rd = 5'd13; step();
    ld_issue = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'h77;
    mem_rvalid = 1'b1; mem_rdata = 32'h5A;
    expect_wr(5'd6, 32'h5A);
    step();
    alu_valid = 1'b0; mem_rvalid = 1'b0;
    chk("pre_reset_held", {31'd0, alu_ready}, 32'd0);
    chk("pre_reset_busy", busy_mask, exp_busy(32'h0000_2100));
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (4) step();
    chk("post_reset_no_write", {31'd0, regwrite}, 32'd0);
    chk("post_reset_busy", busy_mask, 32'd0);
    chk("post_reset_alu_ready", {31'd0, alu_ready}, 32'd1);
    chk("post_reset_ld_ready", {31'd0, ld_ready}, 32'd1);
    chk("pending_expected_writes", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_writeback_unit
`default_nettype wire
